// File: rtl/tube_scan_ctrl.sv
// Bus-mapped scan controller for the two 4-digit hex tube groups and the sign tube.
// Optional build macro TUBE_ZERO_BLANK_EN blanks leading-zero digits within each group.
module tube_scan_ctrl #(
    parameter int SCAN_DIV = 25000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  digital_tube0,
    output logic [3:0]  digital_tube_sel0,
    output logic [7:0]  digital_tube1,
    output logic [3:0]  digital_tube_sel1,
    output logic [7:0]  digital_tube2,
    output logic        digital_tube_sel2
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic [31:0]   data_q, data_d;
    logic [7:0]    dp_q, dp_d;
    logic          en_q, en_d;
    logic          minus_q, minus_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    pos_q, pos_d;

    logic [7:0] tube0_q, tube0_d;
    logic [3:0] sel0_q, sel0_d;
    logic [7:0] tube1_q, tube1_d;
    logic [3:0] sel1_q, sel1_d;
    logic [7:0] tube2_q, tube2_d;
    logic       sel2_q, sel2_d;

    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

`ifdef TUBE_ZERO_BLANK_EN
    // Position p > 0 is a leading zero when nibbles p..3 of the group are all zero.
    function automatic logic lead_zero(input logic [15:0] g, input logic [1:0] p);
        case (p)
            2'd1:    lead_zero = (g[15:4] == 12'h000);
            2'd2:    lead_zero = (g[15:8] == 8'h00);
            2'd3:    lead_zero = (g[15:12] == 4'h0);
            default: lead_zero = 1'b0;
        endcase
    endfunction
`endif

    always_comb begin
        rdata = 32'h0;
        case (addr)
            2'd0:    rdata = data_q;
            2'd1:    rdata = {14'h0, minus_q, en_q, 8'h00, dp_q};
            2'd2:    rdata = {30'h0, pos_q};
            default: rdata = 32'h0;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        dp_d    = dp_q;
        en_d    = en_q;
        minus_d = minus_q;
        if (we && addr == 2'd0) begin
            for (int b = 0; b < 4; b++) begin
                if (byteen[b]) data_d[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        if (we && addr == 2'd1) begin
            if (byteen[0]) dp_d = wdata[7:0];
            if (byteen[2]) begin
                en_d    = wdata[16];
                minus_d = wdata[17];
            end
        end
    end

    // Scan is held at zero while disabled and also at the edge that clears or sets EN,
    // so a re-enable always starts from position 0 with a fresh count.
    always_comb begin
        cnt_d = cnt_q;
        pos_d = pos_q;
        if (!en_q || !en_d) begin
            cnt_d = '0;
            pos_d = 2'd0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            pos_d = pos_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    logic [15:0] grp0, grp1;
    logic [3:0]  nib0, nib1;
    logic        dp0, dp1, blank0, blank1;

    always_comb begin
        grp0 = data_q[15:0];
        grp1 = data_q[31:16];
        nib0 = grp0[{pos_q, 2'b00} +: 4];
        nib1 = grp1[{pos_q, 2'b00} +: 4];
        dp0  = dp_q[{1'b0, pos_q}];
        dp1  = dp_q[{1'b1, pos_q}];
`ifdef TUBE_ZERO_BLANK_EN
        blank0 = lead_zero(grp0, pos_q);
        blank1 = lead_zero(grp1, pos_q);
`else
        blank0 = 1'b0;
        blank1 = 1'b0;
`endif
        tube0_d = 8'hFF;
        sel0_d  = 4'b0000;
        tube1_d = 8'hFF;
        sel1_d  = 4'b0000;
        tube2_d = 8'hFF;
        sel2_d  = 1'b0;
        if (en_q) begin
            sel0_d  = 4'b0001 << pos_q;
            sel1_d  = 4'b0001 << pos_q;
            tube0_d = blank0 ? {~dp0, 7'h7F} : ~{dp0, hex7(nib0)};
            tube1_d = blank1 ? {~dp1, 7'h7F} : ~{dp1, hex7(nib1)};
            tube2_d = minus_q ? 8'hBF : 8'hFF;
            sel2_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= 32'h0;
            dp_q    <= 8'h00;
            en_q    <= 1'b1;
            minus_q <= 1'b0;
            cnt_q   <= '0;
            pos_q   <= 2'd0;
            tube0_q <= 8'hFF;
            sel0_q  <= 4'b0000;
            tube1_q <= 8'hFF;
            sel1_q  <= 4'b0000;
            tube2_q <= 8'hFF;
            sel2_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            dp_q    <= dp_d;
            en_q    <= en_d;
            minus_q <= minus_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            tube0_q <= tube0_d;
            sel0_q  <= sel0_d;
            tube1_q <= tube1_d;
            sel1_q  <= sel1_d;
            tube2_q <= tube2_d;
            sel2_q  <= sel2_d;
        end
    end

    assign digital_tube0     = tube0_q;
    assign digital_tube_sel0 = sel0_q;
    assign digital_tube1     = tube1_q;
    assign digital_tube_sel1 = sel1_q;
    assign digital_tube2     = tube2_q;
    assign digital_tube_sel2 = sel2_q;

endmodule

// File: tb/tb_tube_scan_ctrl.sv
// Directed scoreboard bench for tube_scan_ctrl with SCAN_DIV = 4.
// Honours TUBE_ZERO_BLANK_EN to select the leading-zero expectations.
module tb_tube_scan_ctrl;

    logic        clk;
    logic        reset;
    logic        we;
    logic [1:0]  addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  digital_tube0;
    logic [3:0]  digital_tube_sel0;
    logic [7:0]  digital_tube1;
    logic [3:0]  digital_tube_sel1;
    logic [7:0]  digital_tube2;
    logic        digital_tube_sel2;

    tube_scan_ctrl #(.SCAN_DIV(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .we                (we),
        .addr              (addr),
        .byteen            (byteen),
        .wdata             (wdata),
        .rdata             (rdata),
        .digital_tube0     (digital_tube0),
        .digital_tube_sel0 (digital_tube_sel0),
        .digital_tube1     (digital_tube1),
        .digital_tube_sel1 (digital_tube_sel1),
        .digital_tube2     (digital_tube2),
        .digital_tube_sel2 (digital_tube_sel2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int K_T0 = 0, K_S0 = 1, K_T1 = 2, K_S1 = 3, K_T2 = 4, K_S2 = 5, K_RD = 6;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        we     = 1'b1;
        addr   = a;
        wdata  = d;
        byteen = be;
        @(negedge clk);
        we     = 1'b0;
        byteen = 4'h0;
    endtask

    task automatic push_exp(input string tag, input int kind, input logic [31:0] v);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [31:0] obs;
        e = sb.pop_front();
        case (e.kind)
            K_T0:    obs = {24'h0, digital_tube0};
            K_S0:    obs = {28'h0, digital_tube_sel0};
            K_T1:    obs = {24'h0, digital_tube1};
            K_S1:    obs = {28'h0, digital_tube_sel1};
            K_T2:    obs = {24'h0, digital_tube2};
            K_S2:    obs = {31'h0, digital_tube_sel2};
            default: obs = rdata;
        endcase
        checks++;
        assert (obs === e.exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
        end
    endtask

    task automatic chk(input string tag, input int kind, input logic [31:0] v);
        push_exp(tag, kind, v);
        checkOutput();
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] v);
        addr = a;
        #1;
        chk(tag, K_RD, v);
    endtask

    task automatic chk_all(input string tag, input logic [7:0] t0, input logic [3:0] s0,
                           input logic [7:0] t1, input logic [3:0] s1,
                           input logic [7:0] t2, input logic s2);
        chk({tag, "_tube0"}, K_T0, {24'h0, t0});
        chk({tag, "_sel0"},  K_S0, {28'h0, s0});
        chk({tag, "_tube1"}, K_T1, {24'h0, t1});
        chk({tag, "_sel1"},  K_S1, {28'h0, s1});
        chk({tag, "_tube2"}, K_T2, {24'h0, t2});
        chk({tag, "_sel2"},  K_S2, {31'h0, s2});
    endtask

    logic [7:0] exp_g0 [4];
    logic [7:0] exp_g1 [4];

    initial begin
        reset  = 1'b1;
        we     = 1'b0;
        addr   = 2'd0;
        byteen = 4'h0;
        wdata  = 32'h0;
        $display("[TB] start");

        tick(2);
        chk_all("reset", 8'hFF, 4'b0000, 8'hFF, 4'b0000, 8'hFF, 1'b0);
        chk_reg("reset_data", 2'd0, 32'h0000_0000);
        chk_reg("reset_ctrl", 2'd1, 32'h0001_0000);
        chk_reg("reset_status", 2'd2, 32'h0);
        chk_reg("reserved_read", 2'd3, 32'h0);

        reset = 1'b0;
        tick(1);
        chk_all("first_edge", 8'hC0, 4'b0001, 8'hC0, 4'b0001, 8'hFF, 1'b1);

        // Disable, load data, then re-enable so pos starts from a known edge.
        applyStimulus(2'd1, 32'h0000_0000, 4'b0100);
        applyStimulus(2'd0, 32'h8FCE_1234, 4'b1111);
        applyStimulus(2'd1, 32'h0001_0000, 4'b0100);
        chk_reg("data_readback", 2'd0, 32'h8FCE_1234);
        for (int k = 0; k < 5; k++) begin
            tick(k == 0 ? 1 : 4);
            chk_reg($sformatf("status_%0d", k), 2'd2, 32'(k % 4));
            chk($sformatf("sel0_%0d", k), K_S0, 32'(4'b0001 << (k % 4)));
            chk($sformatf("sel1_%0d", k), K_S1, 32'(4'b0001 << (k % 4)));
            if (k == 0) begin
                chk("pos0_tube0", K_T0, 32'h99);
                chk("pos0_tube1", K_T1, 32'h86);
            end
            if (k == 1) begin
                chk("pos1_tube0", K_T0, 32'hB0);
                chk("pos1_tube1", K_T1, 32'hC6);
            end
        end

        applyStimulus(2'd0, 32'hFFFF_FFFF, 4'b0010);
        chk_reg("byteen_1", 2'd0, 32'h8FCE_FF34);
        applyStimulus(2'd0, 32'h0000_0000, 4'b0000);
        chk_reg("byteen_0", 2'd0, 32'h8FCE_FF34);
        applyStimulus(2'd2, 32'hFFFF_FFFF, 4'b1111);
        applyStimulus(2'd3, 32'hFFFF_FFFF, 4'b1111);
        chk_reg("ro_write_data", 2'd0, 32'h8FCE_FF34);
        chk_reg("ro_write_ctrl", 2'd1, 32'h0001_0000);

        applyStimulus(2'd1, 32'h0002_0001, 4'b1111);
        chk_reg("dis_status_now", 2'd2, 32'h0);
        chk_reg("dis_ctrl", 2'd1, 32'h0002_0001);
        tick(1);
        chk_all("disabled", 8'hFF, 4'b0000, 8'hFF, 4'b0000, 8'hFF, 1'b0);
        tick(5);
        chk_reg("dis_status_held", 2'd2, 32'h0);

        applyStimulus(2'd1, 32'h0003_0001, 4'b1111);
        tick(1);
        chk_all("minus_dp", 8'h19, 4'b0001, 8'h86, 4'b0001, 8'hBF, 1'b1);

        tick(7);
        chk_reg("pre_reset_status", 2'd2, 32'h2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk_all("mid_reset", 8'hFF, 4'b0000, 8'hFF, 4'b0000, 8'hFF, 1'b0);
        chk_reg("mid_reset_data", 2'd0, 32'h0);
        chk_reg("mid_reset_ctrl", 2'd1, 32'h0001_0000);
        chk_reg("mid_reset_status", 2'd2, 32'h0);
        tick(1);
        chk_all("post_reset", 8'hC0, 4'b0001, 8'hC0, 4'b0001, 8'hFF, 1'b1);

`ifdef TUBE_ZERO_BLANK_EN
        exp_g0 = '{8'hC0, 8'h99, 8'hFF, 8'hFF};
        exp_g1 = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
`else
        exp_g0 = '{8'hC0, 8'h99, 8'hC0, 8'hC0};
        exp_g1 = '{8'hC0, 8'hC0, 8'hC0, 8'hC0};
`endif
        applyStimulus(2'd1, 32'h0000_0000, 4'b0100);
        applyStimulus(2'd0, 32'h0000_0040, 4'b1111);
        applyStimulus(2'd1, 32'h0001_0000, 4'b0100);
        for (int p = 0; p < 4; p++) begin
            tick(p == 0 ? 1 : 4);
            chk($sformatf("zb_g0_p%0d", p), K_T0, {24'h0, exp_g0[p]});
            chk($sformatf("zb_g1_p%0d", p), K_T1, {24'h0, exp_g1[p]});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
